// File: rtl/ring_mon_pkg.sv
// Shared constants and state encoding for the one-hot ring counter monitor.
package ring_mon_pkg;

    localparam int              RING_W       = 8;
    localparam int              LOCK_CNT_DEF = 8;
    localparam logic [RING_W-1:0] RING_HOME  = 8'h80;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

    // A healthy ring moves its single set bit one place toward bit 0 each clock.
    function automatic logic [RING_W-1:0] rot_right(input logic [RING_W-1:0] v);
        return {v[0], v[RING_W-1:1]};
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational 8->3 encoder; vld is high only when exactly one input bit is set.
module onehot_enc
    import ring_mon_pkg::*;
(
    input  logic [RING_W-1:0] vec,
    output logic [2:0]        idx,
    output logic              vld
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < RING_W; i++) begin
            if (vec[i]) idx = 3'(i);
        end
        vld = (vec != '0) && ((vec & (vec - 8'd1)) == '0);
    end

endmodule

// File: rtl/ring_mon.sv
// Monitors an upstream rotating one-hot ring counter: locks after LOCK_CNT good
// rotations, counts revolutions while locked and reports/accumulates errors.
module ring_mon
    import ring_mon_pkg::*;
#(
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int ERR_W    = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [7:0]       count,
    input  logic             clr_err,
    output logic [2:0]       position,
    output logic             pos_vld,
    output logic [7:0]       rev_count,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT);

    state_e             state_q, state_d;
    logic [3:0]         streak_q, streak_d;
    logic [7:0]         prev_q, prev_d;
    logic [2:0]         position_q, position_d;
    logic               pos_vld_q, pos_vld_d;
    logic [7:0]         rev_q, rev_d;
    logic               err_oh_q, err_oh_d;
    logic               err_seq_q, err_seq_d;
    logic               sticky_q, sticky_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic [2:0]         enc_idx;
    logic               enc_vld;
    logic               match;

    onehot_enc u_enc (
        .vec (count),
        .idx (enc_idx),
        .vld (enc_vld)
    );

    // prev only ever holds a one-hot value when TRACK/LOCKED consult it,
    // so a match also implies the sample is one-hot.
    assign match = (count == rot_right(prev_q));

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        prev_d     = count;
        position_d = position_q;
        rev_d      = rev_q;
        err_oh_d   = 1'b0;
        err_seq_d  = 1'b0;
        sticky_d   = sticky_q;
        err_cnt_d  = err_cnt_q;

        // Clear is applied before any same-cycle LOCKED error below.
        if (clr_err) begin
            sticky_d  = 1'b0;
            err_cnt_d = '0;
        end

        if (enc_vld && state_q != ST_FAULT) position_d = enc_idx;

        case (state_q)
            ST_SEARCH: begin
                if (enc_vld) begin
                    state_d  = ST_TRACK;
                    streak_d = 4'd1;
                end else begin
                    err_oh_d = 1'b1;
                end
            end
            ST_TRACK: begin
                if (match) begin
                    streak_d = streak_q + 4'd1;
                    if (streak_q + 4'd1 == LOCK_LAST) state_d = ST_LOCKED;
                end else begin
                    state_d   = ST_SEARCH;
                    streak_d  = 4'd0;
                    err_oh_d  = !enc_vld;
                    err_seq_d = enc_vld;
                end
            end
            ST_LOCKED: begin
                if (match) begin
                    if (count == RING_HOME) rev_d = rev_q + 8'd1;
                end else begin
                    state_d   = ST_FAULT;
                    streak_d  = 4'd0;
                    err_oh_d  = !enc_vld;
                    err_seq_d = enc_vld;
                    sticky_d  = 1'b1;
                    if (err_cnt_d != '1) err_cnt_d = err_cnt_d + ERR_W'(1);
                end
            end
            default: begin
                state_d  = ST_SEARCH;
                streak_d = 4'd0;
            end
        endcase

        pos_vld_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_SEARCH;
            streak_q   <= '0;
            prev_q     <= '0;
            position_q <= '0;
            pos_vld_q  <= 1'b0;
            rev_q      <= '0;
            err_oh_q   <= 1'b0;
            err_seq_q  <= 1'b0;
            sticky_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            prev_q     <= prev_d;
            position_q <= position_d;
            pos_vld_q  <= pos_vld_d;
            rev_q      <= rev_d;
            err_oh_q   <= err_oh_d;
            err_seq_q  <= err_seq_d;
            sticky_q   <= sticky_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign state      = state_q;
    assign position   = position_q;
    assign pos_vld    = pos_vld_q;
    assign rev_count  = rev_q;
    assign err_onehot = err_oh_q;
    assign err_seq    = err_seq_q;
    assign err_sticky = sticky_q;
    assign err_count  = err_cnt_q;

endmodule

// File: doc/ring_mon.md
RING_MON -- requirements
Module: ring_mon

Interface
REQ-001 Parameter LOCK_CNT, default 8: number of consecutive correct rotations needed to enter LOCKED (range 2..15).
REQ-002 Parameter ERR_W, default 4: width of the saturating error counter.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rstb, input, 1: reset, asynchronous and active-low.
REQ-005 Port count, input, 8: sample of the upstream 8-bit ring counter (reset 8'h80); a healthy sequence rotates right each clock: 80,40,20,10,08,04,02,01,80.
REQ-006 Port clr_err, input, 1: synchronous clear of the sticky error and the error counter.
REQ-007 Port position, output, 3: index of the set bit in the last sample.
REQ-008 Port pos_vld, output, 1: high only while the state is LOCKED.
REQ-009 Port rev_count, output, 8: number of completed revolutions while LOCKED; wraps 255->0.
REQ-010 Port err_onehot, output, 1: one-cycle pulse when a sample has zero or more than one bit set.
REQ-011 Port err_seq, output, 1: one-cycle pulse when a sample is one-hot but differs from the expected rotation.
REQ-012 Port err_sticky, output, 1: set by any error detected in LOCKED; held until clr_err is asserted.
REQ-013 Port err_count, output, ERR_W: counts errors detected in LOCKED; saturates at all-ones.
REQ-014 Port state, output, 2: current state encoding.

Function
REQ-015 All outputs shall be registered, and shall reflect the sample from the previous clock (1-cycle latency).
REQ-016 The expected value shall be {prev[0], prev[7:1]}, where prev is the previous sample.
REQ-017 States: SEARCH=0, TRACK=1, LOCKED=2, FAULT=3.
REQ-018 SEARCH: on a valid one-hot sample, go to TRACK with streak=1; otherwise stay, and pulse err_onehot.
REQ-019 TRACK: on a sample equal to expected, increment streak; when streak reaches LOCK_CNT, go to LOCKED.
REQ-020 TRACK: on a mismatch, return to SEARCH and pulse err_onehot or err_seq; err_sticky and err_count shall not change.
REQ-021 LOCKED: on a sample equal to expected, stay; when the sample is 8'h80, increment rev_count.
REQ-022 LOCKED: on a mismatch, go to FAULT, pulse the matching error flag, set err_sticky, and increment err_count (saturating).
REQ-023 FAULT shall last exactly one cycle, then go to SEARCH; the sample taken during FAULT shall be ignored.
REQ-024 rev_count shall hold its value outside LOCKED and shall not clear on loss of lock.
REQ-025 clr_err in the same cycle as a LOCKED error: apply the clear first, then the error, giving err_count=1 and err_sticky=1.
REQ-026 position shall be updated only for valid one-hot samples, and shall hold otherwise.

Reset
REQ-027 While rstb is low: state=SEARCH, streak=0, prev=0, position=0, pos_vld=0, rev_count=0, err_count=0, and all error flags 0.
REQ-028 Reset assertion mid-operation shall take effect immediately regardless of state.
REQ-029 After rstb deasserts, the first sample shall be processed as a normal SEARCH sample.

Structure
REQ-030 A shared package shall hold the state encodings, the LOCK_CNT default, and the ring width constant 8.
REQ-031 One sub-module, onehot_enc, shall provide the combinational 8->3 encoder with a one-hot valid flag; all other logic resides in ring_mon.

Verification
REQ-032 Reset release with a healthy ring from 8'h80: state is TRACK after 1 clock and LOCKED after 8 clocks; pos_vld=1; rev_count=1 at the next 8'h80.
REQ-033 In LOCKED, drive 8'h24 once: err_onehot pulses for 1 cycle, state goes FAULT then SEARCH, err_sticky=1, err_count=1.
REQ-034 In LOCKED at 8'h10, drive 8'h04 instead of 8'h08: err_seq pulses, err_count increments; after relock, rev_count resumes from its held value.
REQ-035 Inject 20 LOCKED errors with ERR_W=4: err_count saturates at 15; clr_err coincident with the 21st error gives err_count=1 and err_sticky=1.
REQ-036 Assert rstb low while LOCKED with rev_count=37: all outputs are zero immediately, with no clock edge required.
REQ-037 In TRACK, drive 8'h00: err_onehot pulses, state returns to SEARCH, err_sticky stays 0 and err_count stays 0.
